// File: rtl/pipeline_pkg.sv
// Shared definitions for the writeback stage: control/inst-type bit positions and FSM states.
package pipeline_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CTL_W     = 22;
  localparam int unsigned IT_W      = 6;
  localparam int unsigned SQ_CNT_W  = 3;

  // Control word fields
  localparam int unsigned CTL_RD_LO = 0;
  localparam int unsigned CTL_WE    = 3;
  localparam int unsigned CTL_LOADS = 8;

  // One-hot instruction class bits
  localparam int unsigned IT_LDR    = 0;
  localparam int unsigned IT_STR    = 1;
  localparam int unsigned IT_BLX    = 3;
  localparam int unsigned IT_BX     = 4;
  localparam int unsigned IT_HALT   = 5;

  // Register written by a branch-and-link
  localparam logic [2:0]  LINK_REG  = 3'd7;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_squash_ctr.sv
// Wrong-path slot counter: loads the squash depth on a taken branch, then counts down to zero.
module wb_squash_ctr
  import pipeline_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_squashing
);

  logic [SQ_CNT_W-1:0] r_cnt;

  // Load on a taken branch, otherwise decrement until zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= SQ_CNT_W'(SQUASH_DEPTH);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - SQ_CNT_W'(1);
    end
  end

  assign o_squashing = (r_cnt != '0);

endmodule

// File: rtl/pipeline_4_writeback.sv
// Final pipeline stage: result capture, register-file write port, flags, branch redirect,
// wrong-path squashing and the HALT drain state machine.
module pipeline_4_writeback
  import pipeline_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 3,
  parameter int unsigned RF_ADDR_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          result_in,
  input  logic [21:0]          control_in,
  input  logic [5:0]           inst_type_in,
  input  logic [15:0]          pc_link_in,
  input  logic [15:0]          rdata_mem,
  input  logic                 N_in,
  input  logic                 V_in,
  input  logic                 Z_in,
  input  logic                 branch_take_in,
  input  logic [15:0]          branch_tgt_in,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [15:0]          rf_wdata,
  output logic                 N_flag,
  output logic                 Z_flag,
  output logic                 V_flag,
  output logic                 pc_load,
  output logic [15:0]          pc_target,
  output logic                 squashing,
  output logic                 halted
);

  logic [DATA_W-1:0] r_result;
  logic [CTL_W-1:0]  r_control;
  logic [IT_W-1:0]   r_inst_type;
  logic [DATA_W-1:0] r_pc_link;
  logic              r_n_in;
  logic              r_z_in;
  logic              r_v_in;

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;

  logic              w_run;
  logic              w_squashed;
  logic              w_is_ldr;
  logic              w_is_str;
  logic              w_is_blx;
  logic              w_is_bx;
  logic              w_is_halt;
  logic              w_halt_wb;
  logic              w_take;
  logic              w_unused;

  // WB capture registers: one cycle behind the memory stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_control   <= '0;
      r_inst_type <= '0;
      r_pc_link   <= '0;
      r_n_in      <= 1'b0;
      r_z_in      <= 1'b0;
      r_v_in      <= 1'b0;
    end else begin
      r_result    <= result_in;
      r_control   <= control_in;
      r_inst_type <= inst_type_in;
      r_pc_link   <= pc_link_in;
      r_n_in      <= N_in;
      r_z_in      <= Z_in;
      r_v_in      <= V_in;
    end
  end

  assign w_is_ldr  = r_inst_type[IT_LDR];
  assign w_is_str  = r_inst_type[IT_STR];
  assign w_is_blx  = r_inst_type[IT_BLX];
  assign w_is_bx   = r_inst_type[IT_BX];
  assign w_is_halt = r_inst_type[IT_HALT];

  // A live HALT in WB pre-empts any branch arriving in the same cycle
  assign w_halt_wb = w_is_halt & ~w_squashed & w_run;
  assign w_take    = branch_take_in & ~w_squashed & w_run & ~w_halt_wb;

  // Writeback data select: link PC, then load data, then ALU result
  always_comb begin
    rf_wdata = r_result;
    if (w_is_blx) begin
      rf_wdata = r_pc_link;
    end else if (w_is_ldr) begin
      rf_wdata = rdata_mem;
    end
  end

  assign rf_waddr = w_is_blx ? RF_ADDR_W'(LINK_REG) : r_control[CTL_RD_LO +: RF_ADDR_W];
  assign rf_we    = r_control[CTL_WE] & ~w_squashed & w_run
                  & ~(w_is_str | w_is_bx | w_is_halt);

  // Architectural flags commit at the end of a live flag-setting WB slot
  always_ff @(posedge clk) begin
    if (rst) begin
      N_flag <= 1'b0;
      Z_flag <= 1'b0;
      V_flag <= 1'b0;
    end else if (r_control[CTL_LOADS] & ~w_squashed & w_run) begin
      N_flag <= r_n_in;
      Z_flag <= r_z_in;
      V_flag <= r_v_in;
    end
  end

  // Single-cycle PC redirect for an accepted branch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_load   <= 1'b0;
      pc_target <= '0;
    end else begin
      pc_load <= w_take;
      if (w_take) begin
        pc_target <= branch_tgt_in;
      end
    end
  end

  wb_squash_ctr #(
    .SQUASH_DEPTH (SQUASH_DEPTH)
  ) u_squash_ctr (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_take),
    .o_squashing (w_squashed)
  );

  assign squashing = w_squashed;

  // HALT FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // HALT FSM next state: drain outstanding squash slots before stopping
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_is_halt && !w_squashed) w_state_nxt = DRAIN;
      DRAIN:   if (!w_squashed)              w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  // HALT FSM outputs
  always_comb begin
    w_run  = (r_state == RUN);
    halted = (r_state == HALTED);
  end

  // Control and class bits this stage does not consume
  assign w_unused = ^{r_control[CTL_W-1:CTL_LOADS+1], r_control[CTL_LOADS-1:CTL_WE+1],
                      r_inst_type[2]};

endmodule

// File: tb/tb_pipeline_4_writeback.sv
// Self-checking bench for pipeline_4_writeback using a write-port scoreboard.
module tb_pipeline_4_writeback;

  logic        clk;
  logic        rst;
  logic [15:0] result_in;
  logic [21:0] control_in;
  logic [5:0]  inst_type_in;
  logic [15:0] pc_link_in;
  logic [15:0] rdata_mem;
  logic        N_in;
  logic        V_in;
  logic        Z_in;
  logic        branch_take_in;
  logic [15:0] branch_tgt_in;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        N_flag;
  logic        Z_flag;
  logic        V_flag;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        squashing;
  logic        halted;

  int checks;
  int errors;

  localparam logic [5:0] T_NONE = 6'b000000;
  localparam logic [5:0] T_LDR  = 6'b000001;
  localparam logic [5:0] T_STR  = 6'b000010;
  localparam logic [5:0] T_BLX  = 6'b001000;
  localparam logic [5:0] T_BX   = 6'b010000;
  localparam logic [5:0] T_HALT = 6'b100000;

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  pipeline_4_writeback #(
    .SQUASH_DEPTH (3),
    .RF_ADDR_W    (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .result_in      (result_in),
    .control_in     (control_in),
    .inst_type_in   (inst_type_in),
    .pc_link_in     (pc_link_in),
    .rdata_mem      (rdata_mem),
    .N_in           (N_in),
    .V_in           (V_in),
    .Z_in           (Z_in),
    .branch_take_in (branch_take_in),
    .branch_tgt_in  (branch_tgt_in),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .N_flag         (N_flag),
    .Z_flag         (Z_flag),
    .V_flag         (V_flag),
    .pc_load        (pc_load),
    .pc_target      (pc_target),
    .squashing      (squashing),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] mk_ctl(input logic [2:0] rd, input logic we, input logic loads);
    logic [21:0] c;
    c      = 22'h0;
    c[2:0] = rd;
    c[3]   = we;
    c[8]   = loads;
    return c;
  endfunction

  // One pipeline slot: drive a new instruction plus the WB-aligned inputs (rdata, branch),
  // compare the instruction currently in WB against the scoreboard, queue the new expectation.
  task automatic slot(input logic [21:0] ctl, input logic [5:0] it, input logic [15:0] res,
                      input logic [15:0] link, input logic [15:0] rd,
                      input logic nin, input logic zin, input logic vin,
                      input logic bt, input logic [15:0] tgt,
                      input logic e_we, input logic [2:0] e_a, input logic [15:0] e_d);
    exp_t head;
    control_in     = ctl;
    inst_type_in   = it;
    result_in      = res;
    pc_link_in     = link;
    N_in           = nin;
    Z_in           = zin;
    V_in           = vin;
    branch_take_in = bt;
    branch_tgt_in  = tgt;
    rdata_mem      = (exp_q.size() > 0) ? exp_q[0].rdata : 16'h0000;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      head = exp_q.pop_front();
      checks++;
      if (rf_we !== head.we) begin
        errors++;
        $display("FAIL wb_we: got %b expected %b at %0t", rf_we, head.we, $time);
      end else if (head.we) begin
        checks++;
        if (rf_waddr !== head.waddr || rf_wdata !== head.wdata) begin
          errors++;
          $display("FAIL wb_port: got addr %0d data %h expected addr %0d data %h at %0t",
                   rf_waddr, rf_wdata, head.waddr, head.wdata, $time);
        end
      end
    end
    exp_q.push_back('{e_we, e_a, e_d, rd});
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic bt, input logic [15:0] tgt);
    slot(22'h0, T_NONE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, bt, tgt, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic alu(input logic [2:0] rd, input logic [15:0] val, input logic bt,
                     input logic [15:0] tgt, input logic e_we);
    slot(mk_ctl(rd, 1'b1, 1'b0), T_NONE, val, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, bt, tgt,
         e_we, rd, val);
  endtask

  task automatic test_reset;
    rst            = 1'b1;
    result_in      = 16'hFFFF;
    control_in     = 22'h3FFFFF;
    inst_type_in   = T_NONE;
    pc_link_in     = 16'hFFFF;
    rdata_mem      = 16'h0000;
    N_in           = 1'b1;
    V_in           = 1'b1;
    Z_in           = 1'b1;
    branch_take_in = 1'b0;
    branch_tgt_in  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== 20'h0) begin
      errors++;
      $display("FAIL reset_wport: got %b/%0d/%h expected 0/0/0000", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if ({N_flag, Z_flag, V_flag, pc_load, pc_target, squashing, halted} !== 22'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got nzv=%b%b%b pcl=%b tgt=%h sq=%b h=%b expected all 0",
               N_flag, Z_flag, V_flag, pc_load, pc_target, squashing, halted);
    end
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_alu;
    alu(3'd2, 16'h1234, 1'b0, 16'h0, 1'b1);
    alu(3'd6, 16'hA5A5, 1'b0, 16'h0, 1'b1);
    slot(mk_ctl(3'd1, 1'b0, 1'b0), T_NONE, 16'h7777, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0,
         1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
    nop(1'b0, 16'h0);
  endtask

  task automatic test_load_store;
    slot(mk_ctl(3'd5, 1'b1, 1'b0), T_LDR, 16'h1111, 16'h2222, 16'hBEEF, 1'b0, 1'b0, 1'b0,
         1'b0, 16'h0, 1'b1, 3'd5, 16'hBEEF);
    slot(mk_ctl(3'd4, 1'b1, 1'b0), T_STR, 16'h3333, 16'h0, 16'hCAFE, 1'b0, 1'b0, 1'b0,
         1'b0, 16'h0, 1'b0, 3'd4, 16'h0);
    slot(mk_ctl(3'd3, 1'b1, 1'b0), T_BX, 16'h4444, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0,
         1'b0, 16'h0, 1'b0, 3'd3, 16'h0);
    nop(1'b0, 16'h0);
  endtask

  task automatic test_flags;
    slot(mk_ctl(3'd0, 1'b0, 1'b1), T_NONE, 16'h8000, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1,
         1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
    nop(1'b0, 16'h0);
    checks++;
    if ({N_flag, Z_flag, V_flag} !== 3'b101) begin
      errors++;
      $display("FAIL flags_load: got %b%b%b expected 101", N_flag, Z_flag, V_flag);
    end
    nop(1'b0, 16'h0);
    checks++;
    if ({N_flag, Z_flag, V_flag} !== 3'b101) begin
      errors++;
      $display("FAIL flags_hold: got %b%b%b expected 101", N_flag, Z_flag, V_flag);
    end
    slot(mk_ctl(3'd0, 1'b0, 1'b1), T_NONE, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0,
         1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
    nop(1'b0, 16'h0);
    checks++;
    if ({N_flag, Z_flag, V_flag} !== 3'b010) begin
      errors++;
      $display("FAIL flags_reload: got %b%b%b expected 010", N_flag, Z_flag, V_flag);
    end
  endtask

  task automatic test_branch;
    alu(3'd1, 16'h0001, 1'b0, 16'h0, 1'b1);
    alu(3'd2, 16'h2222, 1'b1, 16'h0040, 1'b0);
    checks++;
    if (pc_load !== 1'b1 || pc_target !== 16'h0040 || squashing !== 1'b1) begin
      errors++;
      $display("FAIL branch_redirect: got pcl=%b tgt=%h sq=%b expected 1/0040/1",
               pc_load, pc_target, squashing);
    end
    alu(3'd3, 16'h3333, 1'b1, 16'h0099, 1'b0);
    checks++;
    if (pc_load !== 1'b0) begin
      errors++;
      $display("FAIL branch_pulse: got pc_load %b expected 0", pc_load);
    end
    alu(3'd4, 16'h4444, 1'b0, 16'h0, 1'b0);
    checks++;
    if (pc_load !== 1'b0 || squashing !== 1'b1) begin
      errors++;
      $display("FAIL branch_wrongpath: got pcl=%b sq=%b expected 0/1", pc_load, squashing);
    end
    alu(3'd5, 16'h5555, 1'b0, 16'h0, 1'b1);
    checks++;
    if (squashing !== 1'b0) begin
      errors++;
      $display("FAIL branch_squash_end: got squashing %b expected 0", squashing);
    end
    nop(1'b0, 16'h0);
  endtask

  task automatic test_blx;
    int sq_cycles;
    slot(mk_ctl(3'd3, 1'b1, 1'b0), T_BLX, 16'h5555, 16'h0011, 16'h0, 1'b0, 1'b0, 1'b0,
         1'b0, 16'h0, 1'b1, 3'd7, 16'h0011);
    nop(1'b1, 16'h0080);
    checks++;
    if (pc_load !== 1'b1 || pc_target !== 16'h0080) begin
      errors++;
      $display("FAIL blx_redirect: got pcl=%b tgt=%h expected 1/0080", pc_load, pc_target);
    end
    sq_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (squashing === 1'b1) sq_cycles++;
      nop(1'b0, 16'h0);
    end
    checks++;
    if (sq_cycles != 3) begin
      errors++;
      $display("FAIL blx_squash_len: got %0d cycles expected 3", sq_cycles);
    end
  endtask

  task automatic test_squashed_halt;
    nop(1'b0, 16'h0);
    nop(1'b1, 16'h0123);
    slot(22'h0, T_HALT, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,
         1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++) nop(1'b0, 16'h0);
    alu(3'd1, 16'h0707, 1'b0, 16'h0, 1'b1);
    nop(1'b0, 16'h0);
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL squashed_halt: got halted %b expected 0", halted);
    end
  endtask

  task automatic test_halt;
    logic bt;
    slot(mk_ctl(3'd2, 1'b1, 1'b0), T_HALT, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0,
         1'b0, 16'h0, 1'b0, 3'd2, 16'h0);
    alu(3'd2, 16'h3333, 1'b1, 16'h0100, 1'b0);
    checks++;
    if (pc_load !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_vs_branch: got pcl=%b halted=%b expected 0/0", pc_load, halted);
    end
    nop(1'b0, 16'h0);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter: got halted %b expected 1", halted);
    end
    for (int i = 0; i < 20; i++) begin
      bt = 1'($urandom);
      slot(22'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), bt, 16'($urandom),
           1'b0, 3'd0, 16'h0);
      checks++;
      if (pc_load !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halted_idle: got pcl=%b halted=%b expected 0/1 (iter %0d)",
                 pc_load, halted, i);
      end
    end
  endtask

  task automatic test_reset_mid;
    rst            = 1'b1;
    control_in     = 22'h0;
    inst_type_in   = T_NONE;
    branch_take_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (halted !== 1'b0 || rf_we !== 1'b0 || rf_wdata !== 16'h0 || pc_load !== 1'b0
        || squashing !== 1'b0 || {N_flag, Z_flag, V_flag} !== 3'b000) begin
      errors++;
      $display("FAIL reset_from_halt: got h=%b we=%b d=%h pcl=%b sq=%b nzv=%b%b%b expected 0",
               halted, rf_we, rf_wdata, pc_load, squashing, N_flag, Z_flag, V_flag);
    end
    alu(3'd6, 16'h6666, 1'b0, 16'h0, 1'b1);
    rst            = 1'b1;
    branch_take_in = 1'b1;
    branch_tgt_in  = 16'h0200;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    branch_take_in = 1'b0;
    exp_q.delete();
    checks++;
    if (pc_load !== 1'b0 || squashing !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_branch: got pcl=%b sq=%b expected 0/0", pc_load, squashing);
    end
    alu(3'd3, 16'h4444, 1'b0, 16'h0, 1'b1);
    nop(1'b0, 16'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu();
    test_load_store();
    test_flags();
    test_branch();
    test_blx();
    test_squashed_halt();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
